// File: rtl/param_regfile_if.sv
// Bus bundle for param_regfile: write/link/PC ports, read selects, scoreboard claim and status.
// Master drives the datapath requests; slave is the register file.
interface param_regfile_if #(
    parameter int DW  = 32,
    parameter int AW  = 4,
    parameter int NRD = 3
);
    logic              Ld;
    logic [AW-1:0]     decode_input;
    logic [DW-1:0]     Ds;
    logic              BL;
    logic [DW-1:0]     PC_4_in;
    logic              PCE;
    logic [DW-1:0]     PCin;
    logic [NRD*AW-1:0] S;
    logic              claim;
    logic [AW-1:0]     claim_addr;
    logic [NRD*DW-1:0] Y;
    logic [DW-1:0]     PCout;
    logic [NRD-1:0]    busy;
    logic              claim_stall;
    logic              err;

    modport master (
        output Ld, decode_input, Ds, BL, PC_4_in, PCE, PCin, S, claim, claim_addr,
        input  Y, PCout, busy, claim_stall, err
    );

    modport slave (
        input  Ld, decode_input, Ds, BL, PC_4_in, PCE, PCin, S, claim, claim_addr,
        output Y, PCout, busy, claim_stall, err
    );
endinterface

// File: rtl/param_regfile.sv
// Parametrised register file with write bypass, PC/link paths and a pending-write scoreboard.
// Latency: writes land at the next edge (visible same cycle when BYPASS=1); claim_stall rejects claims at MAX.
module param_regfile #(
    parameter int DW     = 32,
    parameter int NREG   = 16,
    parameter int AW     = 4,
    parameter int NRD    = 3,
    parameter int SBW    = 2,
    parameter int BYPASS = 1
) (
    input  logic            clock,
    input  logic            R,
    param_regfile_if.slave  bus
);
    localparam logic [AW-1:0]  PC_IDX = AW'(NREG - 1);
    localparam logic [AW-1:0]  LR_IDX = AW'(NREG - 2);
    localparam logic [SBW-1:0] MAX    = '1;

    logic [DW-1:0]     regs    [NREG];
    logic [DW-1:0]     reg_nxt [NREG];
    logic [SBW-1:0]    cnt     [NREG];
    logic [SBW-1:0]    cnt_nxt [NREG];
    logic              uf;
    logic              err_q;
    logic              cl, rt;
    logic [NRD*DW-1:0] y_all;
    logic [NRD-1:0]    busy_all;

    always_comb begin
        uf = 1'b0;
        cl = 1'b0;
        rt = 1'b0;
        for (int j = 0; j < NREG; j++) begin
            cl         = bus.claim && (bus.claim_addr == AW'(j));
            rt         = bus.Ld && (bus.decode_input == AW'(j));
            cnt_nxt[j] = cnt[j];
            reg_nxt[j] = regs[j];
            if (AW'(j) == PC_IDX) begin
                cnt_nxt[j] = '0;
                if (bus.PCE) reg_nxt[j] = bus.PCin;
            end else begin
                // A claim and retire to the same register cancel out.
                if (cl && !rt) begin
                    if (cnt[j] != MAX) cnt_nxt[j] = cnt[j] + SBW'(1);
                end else if (rt && !cl) begin
                    if (cnt[j] == '0) uf = 1'b1;
                    else              cnt_nxt[j] = cnt[j] - SBW'(1);
                end
                if (bus.BL && (AW'(j) == LR_IDX)) reg_nxt[j] = bus.PC_4_in;
                else if (rt)                      reg_nxt[j] = bus.Ds;
            end
        end
    end

    always_ff @(posedge clock or negedge R) begin
        if (!R) begin
            for (int j = 0; j < NREG; j++) begin
                regs[j] <= '0;
                cnt[j]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            regs  <= reg_nxt;
            cnt   <= cnt_nxt;
            err_q <= err_q | uf;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]  sel;
        logic [DW-1:0]  rd;
        logic [SBW-1:0] c;
        assign sel = bus.S[i*AW +: AW];
        assign c   = cnt[sel];

        always_comb begin
            rd = regs[sel];
            if (BYPASS != 0 && R && bus.BL && sel == LR_IDX)
                rd = bus.PC_4_in;
            else if (BYPASS != 0 && R && bus.Ld && sel == bus.decode_input && sel != PC_IDX)
                rd = bus.Ds;
        end

        assign y_all[i*DW +: DW] = R ? rd : '0;
        // The last retire clears busy in its own cycle, matching what the bypass delivers.
        assign busy_all[i] = R && (c != '0) &&
                             !((c == SBW'(1)) && bus.Ld && (bus.decode_input == sel) &&
                               !(bus.claim && bus.claim_addr == sel));
    end

    assign bus.Y           = y_all;
    assign bus.busy        = busy_all;
    assign bus.PCout       = regs[PC_IDX];
    assign bus.err         = err_q;
    assign bus.claim_stall = R && bus.claim && (bus.claim_addr != PC_IDX) &&
                             (cnt[bus.claim_addr] == MAX) &&
                             !(bus.Ld && bus.decode_input == bus.claim_addr);
endmodule

// File: tb/tb_param_regfile.sv
// Bench for param_regfile: two instances (bypass on/off) share stimulus and are compared to an array model.
module tb_param_regfile;
    logic        clock = 1'b0;
    logic        R;
    logic        Ld, BL, PCE, claim;
    logic [3:0]  decode_input, claim_addr;
    logic [31:0] Ds, PC_4_in, PCin;
    logic [11:0] S;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_reg [16];
    int          m_cnt [16];
    bit          m_err;

    always #5 clock = ~clock;

    param_regfile_if #(.DW(32), .AW(4), .NRD(3)) if_b ();
    param_regfile_if #(.DW(32), .AW(4), .NRD(3)) if_n ();

    assign if_b.Ld = Ld;           assign if_n.Ld = Ld;
    assign if_b.decode_input = decode_input; assign if_n.decode_input = decode_input;
    assign if_b.Ds = Ds;           assign if_n.Ds = Ds;
    assign if_b.BL = BL;           assign if_n.BL = BL;
    assign if_b.PC_4_in = PC_4_in; assign if_n.PC_4_in = PC_4_in;
    assign if_b.PCE = PCE;         assign if_n.PCE = PCE;
    assign if_b.PCin = PCin;       assign if_n.PCin = PCin;
    assign if_b.S = S;             assign if_n.S = S;
    assign if_b.claim = claim;     assign if_n.claim = claim;
    assign if_b.claim_addr = claim_addr; assign if_n.claim_addr = claim_addr;

    param_regfile #(.DW(32), .NREG(16), .AW(4), .NRD(3), .SBW(2), .BYPASS(1)) u_byp (
        .clock(clock), .R(R), .bus(if_b));
    param_regfile #(.DW(32), .NREG(16), .AW(4), .NRD(3), .SBW(2), .BYPASS(0)) u_nob (
        .clock(clock), .R(R), .bus(if_n));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_y(input logic [3:0] sel, input bit byp);
        if (!R) return 32'h0;
        if (byp && BL && sel == 4'd14) return PC_4_in;
        if (byp && Ld && sel == decode_input && sel != 4'd15) return Ds;
        return m_reg[sel];
    endfunction

    function automatic logic exp_busy(input logic [3:0] sel);
        if (!R) return 1'b0;
        if (m_cnt[sel] == 0) return 1'b0;
        if (m_cnt[sel] == 1 && Ld && decode_input == sel && !(claim && claim_addr == sel))
            return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_stall();
        return R && claim && claim_addr != 4'd15 && m_cnt[claim_addr] == 3 &&
               !(Ld && decode_input == claim_addr);
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 16; j++) begin
            m_reg[j] = 32'h0;
            m_cnt[j] = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic model_edge();
        if (!R) return;
        if (claim && claim_addr != 4'd15 && !(Ld && decode_input == claim_addr) && m_cnt[claim_addr] < 3)
            m_cnt[claim_addr] = m_cnt[claim_addr] + 1;
        if (Ld && decode_input != 4'd15 && !(claim && claim_addr == decode_input)) begin
            if (m_cnt[decode_input] == 0) m_err = 1'b1;
            else m_cnt[decode_input] = m_cnt[decode_input] - 1;
        end
        if (Ld && decode_input != 4'd15 && !(BL && decode_input == 4'd14)) m_reg[decode_input] = Ds;
        if (BL)  m_reg[14] = PC_4_in;
        if (PCE) m_reg[15] = PCin;
    endtask

    task automatic check_all(input string tag);
        logic [3:0] sel;
        for (int p = 0; p < 3; p++) begin
            sel = S[p*4 +: 4];
            chk({tag, "_y_byp"}, {32'h0, if_b.Y[p*32 +: 32]}, {32'h0, exp_y(sel, 1'b1)});
            chk({tag, "_y_nob"}, {32'h0, if_n.Y[p*32 +: 32]}, {32'h0, exp_y(sel, 1'b0)});
            chk({tag, "_busy"},  {63'h0, if_b.busy[p]}, {63'h0, exp_busy(sel)});
        end
        chk({tag, "_pcout"}, {32'h0, if_b.PCout}, {32'h0, m_reg[15]});
        chk({tag, "_pcout_nob"}, {32'h0, if_n.PCout}, {32'h0, m_reg[15]});
        chk({tag, "_stall"}, {63'h0, if_b.claim_stall}, {63'h0, exp_stall()});
        chk({tag, "_err"}, {63'h0, if_b.err}, {63'h0, m_err});
        chk({tag, "_err_nob"}, {63'h0, if_n.err}, {63'h0, m_err});
    endtask

    // Inputs are held from just after one rising edge to just after the next.
    task automatic cycle(input string tag);
        @(negedge clock);
        check_all(tag);
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle();
        Ld = 0; BL = 0; PCE = 0; claim = 0;
        decode_input = 0; claim_addr = 0;
        Ds = 0; PC_4_in = 0; PCin = 0; S = 0;
    endtask

    initial begin
        R = 1'b0;
        idle();
        model_reset();
        cycle("reset");
        R = 1'b1;

        // Load r3, then pull reset mid-run.
        Ld = 1; decode_input = 4'd3; Ds = 32'h12345678; S = {4'd0, 4'd0, 4'd3};
        cycle("wr3");
        idle(); S = {4'd0, 4'd0, 4'd3};
        #2 chk("rd3", {32'h0, if_b.Y[31:0]}, 64'h12345678);
        R = 1'b0;
        model_reset();
        #2 chk("rst_y0", {32'h0, if_b.Y[31:0]}, 64'h0);
        chk("rst_pcout", {32'h0, if_b.PCout}, 64'h0);
        check_all("rst_mid");
        @(posedge clock); #1;
        R = 1'b1;
        cycle("rd3_after_rst");

        // Write with bypass on and off.
        Ld = 1; decode_input = 4'd5; Ds = 32'hA5A5A5A5; S = {4'd0, 4'd0, 4'd5};
        #2 chk("byp_same", {32'h0, if_b.Y[31:0]}, 64'hA5A5A5A5);
        chk("nob_old", {32'h0, if_n.Y[31:0]}, 64'h0);
        cycle("wr5");
        idle(); S = {4'd0, 4'd0, 4'd5};
        #2 chk("nob_after", {32'h0, if_n.Y[31:0]}, 64'hA5A5A5A5);
        cycle("rd5");

        // Link write beats general write to LR.
        BL = 1; PC_4_in = 32'h104; Ld = 1; decode_input = 4'd14; Ds = 32'hFF; S = {4'd0, 4'd14, 4'd0};
        #2 chk("bl_byp", {32'h0, if_b.Y[63:32]}, 64'h104);
        cycle("bl_ld");
        idle(); S = {4'd0, 4'd14, 4'd0};
        #2 chk("bl_reg", {32'h0, if_n.Y[63:32]}, 64'h104);
        cycle("bl_rd");

        // PC protected from the general port.
        Ld = 1; decode_input = 4'd15; Ds = 32'hDEAD; PCE = 1; PCin = 32'h200; S = {4'd15, 4'd15, 4'd15};
        #2 chk("pc_byp_old", {32'h0, if_b.Y[31:0]}, 64'h0);
        cycle("pc_wr");
        idle(); S = {4'd15, 4'd15, 4'd15};
        #2 chk("pcout", {32'h0, if_b.PCout}, 64'h200);
        chk("pc_read", {32'h0, if_b.Y[95:64]}, 64'h200);
        cycle("pc_rd");

        // Scoreboard saturation, cancel and drain on r2.
        for (int k = 0; k < 3; k++) begin
            idle(); S = {4'd0, 4'd0, 4'd2}; claim = 1; claim_addr = 4'd2;
            cycle("claim");
        end
        idle(); S = {4'd0, 4'd0, 4'd2};
        #2 chk("sb_busy3", {63'h0, if_b.busy[0]}, 64'h1);
        claim = 1; claim_addr = 4'd2;
        #2 chk("sb_stall", {63'h0, if_b.claim_stall}, 64'h1);
        cycle("claim4");
        Ld = 1; decode_input = 4'd2; Ds = 32'h22;
        #2 chk("sb_cancel_nostall", {63'h0, if_b.claim_stall}, 64'h0);
        cycle("claim_ret");
        for (int k = 0; k < 3; k++) begin
            idle(); S = {4'd0, 4'd0, 4'd2}; Ld = 1; decode_input = 4'd2; Ds = 32'h30 + k;
            #2 chk("sb_drain_busy", {63'h0, if_b.busy[0]}, (k == 2) ? 64'h0 : 64'h1);
            cycle("retire");
        end

        // Underflow sets sticky err.
        idle(); Ld = 1; decode_input = 4'd7; Ds = 32'h77;
        cycle("uf");
        idle();
        #2 chk("err_set", {63'h0, if_b.err}, 64'h1);
        for (int k = 0; k < 3; k++) cycle("err_hold");
        chk("err_sticky", {63'h0, if_b.err}, 64'h1);
        R = 1'b0; model_reset();
        #2 chk("err_clr", {63'h0, if_b.err}, 64'h0);
        @(posedge clock); #1;
        R = 1'b1;

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            Ld = ($urandom_range(0, 1) == 1);
            decode_input = 4'($urandom_range(0, 15));
            Ds = $urandom;
            BL = ($urandom_range(0, 7) == 0);
            PC_4_in = $urandom;
            PCE = ($urandom_range(0, 3) == 0);
            PCin = $urandom;
            claim = ($urandom_range(0, 1) == 1);
            claim_addr = 4'($urandom_range(0, 15));
            S = 12'($urandom);
            if ($urandom_range(0, 3) == 0) S[3:0] = decode_input;
            if ($urandom_range(0, 3) == 0) S[7:4] = claim_addr;
            if (!R) R = 1'b1;
            else if ($urandom_range(0, 199) == 0) begin
                R = 1'b0;
                model_reset();
            end
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
